// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control unit: state encoding,
// button-event priority and default timing parameters.
package stopwatch_pkg;

    localparam int DEB_CYC_DEF   = 4;
    localparam int TICK_DIV_DEF  = 5;
    localparam int LAP_DEPTH_DEF = 4;

    // Encoding is visible on o_State, so the values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_VIEW  = 2'd3
    } sw_state_e;

    // Listed from highest to lowest priority after EV_NONE.
    typedef enum logic [1:0] {
        EV_NONE   = 2'd0,
        EV_STOP   = 2'd1,
        EV_START  = 2'd2,
        EV_RECORD = 2'd3
    } btn_ev_e;

    // Collapse simultaneous presses into the single event that acts:
    // stop beats start, start beats record.
    function automatic btn_ev_e pick_event(input logic stop, input logic start,
                                           input logic record);
        btn_ev_e ev;
        ev = EV_NONE;
        if (stop) begin
            ev = EV_STOP;
        end else if (start) begin
            ev = EV_START;
        end else if (record) begin
            ev = EV_RECORD;
        end
        return ev;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_cond.sv
// Button conditioning: 2-flop synchronizer, level debouncer and a
// registered press detector (held level 1 -> 0 gives a one-cycle pulse).
module btn_cond #(
    parameter int DEB_CYC = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_ni,
    output logic press_o
);

    localparam int CW = $clog2(DEB_CYC + 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // Synchronizer, debounce state and press register; idle level is high.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_ni};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // Count consecutive samples that disagree with the held level; once
    // DEB_CYC of them have been seen, flip the level on the following edge.
    // Any agreeing sample restarts the count, so short glitches vanish.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (cnt_q == CW'(DEB_CYC)) begin
            level_d = ~level_q;
            cnt_d   = '0;
            press_d = level_q;
        end else if (sync_q[1] != level_q) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control unit: conditions the three buttons, runs the
// IDLE/RUN/PAUSE/VIEW state machine and drives tick, clear, lap-capture
// and display-select outputs. Every output comes straight from a flop.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEB_CYC   = DEB_CYC_DEF,
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int LAP_DEPTH = LAP_DEPTH_DEF,
    localparam int IDX_W    = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1,
    localparam int CNT_W    = IDX_W + 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             fStart,
    input  logic             fStop,
    input  logic             fRecord,
    output logic             o_Tick,
    output logic             o_Clr,
    output logic             o_LapWr,
    output logic [IDX_W-1:0] o_LapIdx,
    output logic [CNT_W-1:0] o_LapCnt,
    output logic             o_DispLap,
    output logic [1:0]       o_State
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Bit 0 = start, bit 1 = stop, bit 2 = record.
    logic [2:0] btn_raw;
    logic [2:0] press;

    assign btn_raw = {fRecord, fStop, fStart};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            btn_cond #(
                .DEB_CYC(DEB_CYC)
            ) u_btn (
                .clk_i  (Clk),
                .rst_ni (Rst),
                .btn_ni (btn_raw[gi]),
                .press_o(press[gi])
            );
        end
    endgenerate

    btn_ev_e ev;
    assign ev = pick_event(press[1], press[0], press[2]);

    sw_state_e        state_q, state_d;
    sw_state_e        ret_q, ret_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick_q, tick_d;
    logic             clr_q, clr_d;
    logic             lapwr_q, lapwr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             disp_q, disp_d;

    // State, prescaler, lap bookkeeping and registered outputs.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            ret_q   <= ST_IDLE;
            presc_q <= '0;
            tick_q  <= 1'b0;
            clr_q   <= 1'b0;
            lapwr_q <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            clr_q   <= clr_d;
            lapwr_q <= lapwr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
        end
    end

    // Next-state and next-output logic for the accepted button event.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        clr_d   = 1'b0;
        lapwr_d = 1'b0;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        disp_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ev == EV_START) begin
                    state_d = ST_RUN;
                end else if (ev == EV_RECORD && cnt_q != '0) begin
                    state_d = ST_VIEW;
                    idx_d   = '0;
                    ret_d   = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (ev == EV_STOP) begin
                    state_d = ST_PAUSE;
                end else if (ev == EV_RECORD && cnt_q < CNT_W'(LAP_DEPTH)) begin
                    lapwr_d = 1'b1;
                    idx_d   = cnt_q[IDX_W-1:0];
                    cnt_d   = cnt_q + 1'b1;
                end
                // The prescaler only advances (and ticks) while staying in
                // RUN, so the exit cycle never ticks and PAUSE resumes from
                // exactly where counting stopped.
                if (state_d == ST_RUN) begin
                    if (presc_q == PW'(TICK_DIV - 1)) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (ev == EV_START) begin
                    state_d = ST_RUN;
                end else if (ev == EV_STOP) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                    cnt_d   = '0;
                    idx_d   = '0;
                    presc_d = '0;
                end else if (ev == EV_RECORD && cnt_q != '0) begin
                    state_d = ST_VIEW;
                    idx_d   = '0;
                    ret_d   = ST_PAUSE;
                end
            end
            ST_VIEW: begin
                if (ev == EV_STOP) begin
                    state_d = ret_q;
                end else if (ev == EV_START) begin
                    state_d = ST_RUN;
                end else if (ev == EV_RECORD) begin
                    // VIEW is only entered with at least one lap, so cnt_q-1
                    // is the last valid slot.
                    if ({1'b0, idx_q} == cnt_q - CNT_W'(1)) begin
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        disp_d = (state_d == ST_VIEW);
    end

    assign o_Tick    = tick_q;
    assign o_Clr     = clr_q;
    assign o_LapWr   = lapwr_q;
    assign o_LapIdx  = idx_q;
    assign o_LapCnt  = cnt_q;
    assign o_DispLap = disp_q;
    assign o_State   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: stimulus pushes the expected visible
// change (with its arrival edge), a monitor pops and compares whenever the
// outputs change or a strobe fires, and checks tick spacing independently.
module tb_stopwatch_ctrl;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       fStart = 1'b1;
    logic       fStop = 1'b1;
    logic       fRecord = 1'b1;
    logic       o_Tick, o_Clr, o_LapWr, o_DispLap;
    logic [1:0] o_LapIdx;
    logic [2:0] o_LapCnt;
    logic [1:0] o_State;

    stopwatch_ctrl #(
        .DEB_CYC  (4),
        .TICK_DIV (5),
        .LAP_DEPTH(4)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .fStart   (fStart),
        .fStop    (fStop),
        .fRecord  (fRecord),
        .o_Tick   (o_Tick),
        .o_Clr    (o_Clr),
        .o_LapWr  (o_LapWr),
        .o_LapIdx (o_LapIdx),
        .o_LapCnt (o_LapCnt),
        .o_DispLap(o_DispLap),
        .o_State  (o_State)
    );

    always #5 Clk = ~Clk;

    // Index of the most recent rising edge.
    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] st;
        logic [1:0] idx;
        logic [2:0] cnt;
        logic       disp;
        logic       wr;
        logic       clr;
        int         at;
    } txn_t;

    txn_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tick_total = 0;

    // Press latency: low sampled first at edge N, outputs change at N+7.
    localparam int LAT = 7;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // m[0]=start, m[1]=stop, m[2]=record. When has_exp is set, the expected
    // visible change is queued for edge N+LAT.
    task automatic press(input string nm, input logic [2:0] m, input int len,
                         input bit has_exp, input logic [1:0] st,
                         input logic [1:0] idx, input logic [2:0] cnt,
                         input logic disp, input logic wr, input logic clr);
        txn_t t;
        @(posedge Clk);
        #1;
        if (m[0]) fStart = 1'b0;
        if (m[1]) fStop = 1'b0;
        if (m[2]) fRecord = 1'b0;
        if (has_exp) begin
            t.st = st; t.idx = idx; t.cnt = cnt; t.disp = disp;
            t.wr = wr; t.clr = clr; t.at = cyc + 1 + LAT;
            exp_q.push_back(t);
        end
        $display("[%0d] drive %s (mask %b, %0d cycles)", cyc, nm, m, len);
        repeat (len) @(posedge Clk);
        #1;
        fStart = 1'b1;
        fStop = 1'b1;
        fRecord = 1'b1;
        repeat (10) @(posedge Clk);
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 30) begin
            @(posedge Clk);
            k++;
        end
        chk({nm, " pending"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
    endtask

    // Monitor: compare on every visible change, check tick placement.
    logic [1:0] prev_st = 2'd0;
    logic [1:0] prev_idx = 2'd0;
    logic [2:0] prev_cnt = 3'd0;
    logic       prev_disp = 1'b0;
    int         run_entry = 0;
    bit         from_idle = 1'b0;
    int         last_tick = -1;

    always @(negedge Clk) begin
        txn_t t;
        bit   changed;
        changed = (o_State != prev_st) || (o_LapIdx != prev_idx) ||
                  (o_LapCnt != prev_cnt) || (o_DispLap != prev_disp) ||
                  (o_LapWr === 1'b1) || (o_Clr === 1'b1);
        if (changed) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_txn @%0d: st=%0d idx=%0d cnt=%0d disp=%0b wr=%0b clr=%0b, required none",
                         cyc, o_State, o_LapIdx, o_LapCnt, o_DispLap, o_LapWr, o_Clr);
            end else begin
                t = exp_q.pop_front();
                if (o_State !== t.st || o_LapIdx !== t.idx || o_LapCnt !== t.cnt ||
                    o_DispLap !== t.disp || o_LapWr !== t.wr || o_Clr !== t.clr ||
                    cyc != t.at) begin
                    n_bad++;
                    $display("FAIL txn @%0d: got st=%0d idx=%0d cnt=%0d disp=%0b wr=%0b clr=%0b, required @%0d st=%0d idx=%0d cnt=%0d disp=%0b wr=%0b clr=%0b",
                             cyc, o_State, o_LapIdx, o_LapCnt, o_DispLap, o_LapWr, o_Clr,
                             t.at, t.st, t.idx, t.cnt, t.disp, t.wr, t.clr);
                end else begin
                    $display("[%0d] txn ok: st=%0d idx=%0d cnt=%0d disp=%0b wr=%0b clr=%0b",
                             cyc, o_State, o_LapIdx, o_LapCnt, o_DispLap, o_LapWr, o_Clr);
                end
            end
        end

        if (o_State == 2'd1 && prev_st != 2'd1) begin
            run_entry = cyc;
            from_idle = (prev_st == 2'd0);
            last_tick = -1;
        end

        if (o_Tick === 1'b1) begin
            tick_total++;
            n_cmp++;
            if (o_State != 2'd1) begin
                n_bad++;
                $display("FAIL tick_outside_run @%0d: state=%0d, required 1", cyc, o_State);
            end else if (last_tick >= 0) begin
                if (cyc - last_tick != 5) begin
                    n_bad++;
                    $display("FAIL tick_period @%0d: gap=%0d, required 5", cyc, cyc - last_tick);
                end
            end else if (from_idle) begin
                if (cyc - run_entry != 5) begin
                    n_bad++;
                    $display("FAIL first_tick @%0d: delay=%0d, required 5", cyc, cyc - run_entry);
                end
            end
            last_tick = cyc;
        end

        prev_st   = o_State;
        prev_idx  = o_LapIdx;
        prev_cnt  = o_LapCnt;
        prev_disp = o_DispLap;
    end

    initial begin
        txn_t t;
        int   ticks_before;

        // Reset held low for two edges.
        Rst = 1'b0;
        idle(2);
        #1;
        chk("rst_state", o_State, 0);
        chk("rst_tick", o_Tick, 0);
        chk("rst_clr", o_Clr, 0);
        chk("rst_lapwr", o_LapWr, 0);
        chk("rst_idx", o_LapIdx, 0);
        chk("rst_cnt", o_LapCnt, 0);
        chk("rst_disp", o_DispLap, 0);
        Rst = 1'b1;
        idle(50);
        #1;
        chk("idle_ticks", tick_total, 0);
        chk("idle_state", o_State, 0);

        // Start, then a short stop glitch that must be rejected.
        press("start", 3'b001, 10, 1'b1, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        drain("start");
        press("stop_glitch", 3'b010, 3, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        idle(20);
        drain("glitch");
        chk("glitch_state", o_State, 1);
        chk("run_ticks_seen", (tick_total > 0) ? 1 : 0, 1);

        // Four laps captured, fifth ignored.
        for (int i = 0; i < 4; i++) begin
            press("record_run", 3'b100, 6, 1'b1, 2'd1, 2'(i), 3'(i + 1),
                  1'b0, 1'b1, 1'b0);
        end
        press("record_full", 3'b100, 6, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        drain("laps");
        chk("lapcnt_full", o_LapCnt, 4);

        // Pause, browse laps, back to pause.
        press("stop_pause", 3'b010, 6, 1'b1, 2'd2, 2'd3, 3'd4, 1'b0, 1'b0, 1'b0);
        ticks_before = tick_total;
        idle(20);
        chk("pause_no_ticks", tick_total - ticks_before, 0);
        press("record_view", 3'b100, 6, 1'b1, 2'd3, 2'd0, 3'd4, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            press("record_browse", 3'b100, 6, 1'b1, 2'd3, 2'(i % 4), 3'd4,
                  1'b1, 1'b0, 1'b0);
        end
        press("stop_view", 3'b010, 6, 1'b1, 2'd2, 2'd0, 3'd4, 1'b0, 1'b0, 1'b0);
        drain("view");

        // Clear back to IDLE; record alone does nothing there.
        press("stop_clear", 3'b010, 6, 1'b1, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        press("record_idle", 3'b100, 6, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        drain("clear");
        chk("idle_after_clear", o_State, 0);

        // Simultaneous stop+start in RUN: stop wins.
        press("start2", 3'b001, 6, 1'b1, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        idle(8);
        press("stop_start", 3'b011, 6, 1'b1, 2'd2, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        drain("simul");
        chk("simul_state", o_State, 2);

        // Resume, take one lap, then reset mid-run.
        press("resume", 3'b001, 6, 1'b1, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        press("record_run2", 3'b100, 6, 1'b1, 2'd1, 2'd0, 3'd1, 1'b0, 1'b1, 1'b0);
        drain("resume");
        @(posedge Clk);
        #1;
        t.st = 2'd0; t.idx = 2'd0; t.cnt = 3'd0; t.disp = 1'b0;
        t.wr = 1'b0; t.clr = 1'b0; t.at = cyc + 1;
        exp_q.push_back(t);
        Rst = 1'b0;
        @(posedge Clk);
        #1;
        chk("midrst_state", o_State, 0);
        chk("midrst_cnt", o_LapCnt, 0);
        chk("midrst_tick", o_Tick, 0);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        idle(10);
        drain("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, required finish");
        $fatal(1);
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control unit for the stopwatch. It conditions the three active-low push buttons (start, stop, record) and runs the IDLE/RUN/PAUSE/VIEW state machine. It generates the centisecond count-enable tick, the counter clear, and the lap-capture strobes for the time-counter/lap-register datapath. It also selects live or lap display for the 7-segment decoders.

## Interface
- DEB_CYC, 4: consecutive equal synchronized samples required to accept a new button level (≥2)
- TICK_DIV, 5: clocks per count-enable tick (≥2)
- LAP_DEPTH, 4: number of lap slots (power of two, ≤8)
- Clk  in  1  system clock, all logic on rising edge
- Rst  in  1  reset, synchronous, active-low
- fStart  in  1  start/resume button, active-low, asynchronous to Clk
- fStop  in  1  stop/clear button, active-low, asynchronous
- fRecord  in  1  record-lap / browse-lap button, active-low, asynchronous
- o_Tick  out  1  one-cycle count-enable pulse to the time counter
- o_Clr  out  1  one-cycle clear pulse to the time counter
- o_LapWr  out  1  one-cycle capture strobe: live time → lap slot o_LapIdx
- o_LapIdx  out  clog2(LAP_DEPTH)  lap slot being written or displayed
- o_LapCnt  out  clog2(LAP_DEPTH)+1  number of valid laps, 0..LAP_DEPTH
- o_DispLap  out  1  1 = display shows lap o_LapIdx, 0 = live time
- o_State  out  2  IDLE=0, RUN=1, PAUSE=2, VIEW=3

## Operation
- Button path, per button: 2-flop synchronizer → debouncer → press detector.
  - Debouncer: the held level starts at 1 and is replaced only after DEB_CYC consecutive synchronized samples differ from it.
  - Press detector: one-cycle press event on held level 1→0. Release produces nothing.
- Priority on the same cycle: Stop > Start > Record. Only the highest-priority event acts; the others are dropped.
- IDLE:
  - Start → RUN.
  - Record with o_LapCnt>0 → VIEW, o_LapIdx=0, return-state=IDLE.
  - Stop → ignored.
- RUN:
  - Prescaler counts 0..TICK_DIV-1; o_Tick=1 in the cycle the prescaler equals TICK_DIV-1.
  - Stop → PAUSE.
  - Start → ignored.
  - Record with o_LapCnt<LAP_DEPTH → o_LapWr=1, o_LapIdx=o_LapCnt, o_LapCnt+1.
  - Record when full → ignored, no strobe.
- PAUSE:
  - Prescaler holds.
  - Start → RUN; the prescaler resumes from its held value.
  - Stop → IDLE with o_Clr=1; o_LapCnt, o_LapIdx and the prescaler go to 0.
  - Record with o_LapCnt>0 → VIEW, o_LapIdx=0, return-state=PAUSE.
- VIEW:
  - o_DispLap=1; prescaler holds.
  - Record → o_LapIdx+1, wrapping to 0 after o_LapCnt-1.
  - Stop → return-state, o_DispLap=0.
  - Start → RUN, o_DispLap=0.
- o_DispLap=0 in every state except VIEW.
- Record never changes o_LapCnt outside RUN.

## Timing
- Reset values: all outputs 0, state IDLE, return-state IDLE, prescaler 0, debouncer levels 1, synchronizers 1.
- All outputs are registered.
- Press latency: raw button low at rising edge N → state and strobes change at edge N+DEB_CYC+3.
  - 2 cycles synchronizer, DEB_CYC cycles debounce, 1 cycle FSM register.
- Pulses from fewer than DEB_CYC synchronized samples are rejected.
- Holding a button produces exactly one event.
- First o_Tick after IDLE→RUN comes TICK_DIV cycles after the state update; thereafter one every TICK_DIV cycles.
- o_Tick is never asserted outside RUN, including the exit cycle.
- o_Clr and o_LapWr last exactly one cycle per accepted event.
- Reset mid-operation: synchronous return to reset values at the next edge; an in-flight debounce is discarded.

## Structure
- Package stopwatch_pkg holds:
  - state encoding constants (IDLE/RUN/PAUSE/VIEW)
  - button-event priority order
  - default DEB_CYC/TICK_DIV/LAP_DEPTH
- Sub-module btn_cond (synchronizer + debouncer + press detector, parameter DEB_CYC), instantiated three times.
- FSM, prescaler and lap counters live in stopwatch_ctrl.

## Test plan
Defaults for all scenarios: DEB_CYC=4, TICK_DIV=5.
- Rst=0 for 2 cycles, then 1; buttons idle high → all outputs 0, o_State=0, no o_Tick for 50 cycles.
- fStart low 10 cycles → o_State=1 at edge 7 after first low sample; o_Tick every 5 cycles; a 3-cycle glitch on fStop causes no state change.
- In RUN, press fRecord 5 times → o_LapWr pulses with o_LapIdx 0,1,2,3; fifth press gives no strobe; o_LapCnt=4.
- fStop → PAUSE, ticks stop; fRecord → VIEW, o_DispLap=1, o_LapIdx=0; 4 more fRecord presses → o_LapIdx 1,2,3,0; fStop → PAUSE, o_DispLap=0.
- In PAUSE, fStop → IDLE, single o_Clr pulse, o_LapCnt=0; then fRecord alone → stays IDLE.
- fStop and fStart debounced in the same cycle while in RUN → PAUSE only.
- Rst=0 while in RUN → all outputs 0 at the next edge.
